// File: rtl/alu_functional_unit.sv
// ALU execution unit: one-stage operand capture, execute into an in-order
// result FIFO drained by the ROB, with credit return and mispredict flush.
package alu_functional_unit_pkg;
  typedef enum logic [3:0] {
    FU_OP_PLUS   = 4'd0,
    FU_OP_MINUS  = 4'd1,
    FU_OP_AND    = 4'd2,
    FU_OP_ORR    = 4'd3,
    FU_OP_EOR    = 4'd4,
    FU_OP_LSL    = 4'd5,
    FU_OP_LSR    = 4'd6,
    FU_OP_PASS_A = 4'd7,
    FU_OP_CSEL   = 4'd8
  } fu_op_t;
endpackage

module alu_functional_unit
  import alu_functional_unit_pkg::*;
#(
  parameter int unsigned GPR_SIZE     = 64,
  parameter int unsigned ROB_IDX_SIZE = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_start,
  input  fu_op_t                  in_fu_op,
  input  logic [GPR_SIZE-1:0]     in_val_a,
  input  logic [GPR_SIZE-1:0]     in_val_b,
  input  logic [ROB_IDX_SIZE-1:0] in_dst_rob_index,
  input  logic [3:0]              in_nzcv,
  input  logic                    in_set_nzcv,
  input  logic [3:0]              in_cond,
  input  logic                    in_rob_is_mispred,
  input  logic                    in_rob_accept,
  output logic                    out_ready,
  output logic                    out_done,
  output logic [GPR_SIZE-1:0]     out_value,
  output logic [ROB_IDX_SIZE-1:0] out_dst_rob_index,
  output logic                    out_set_nzcv,
  output logic [3:0]              out_nzcv,
  output logic                    out_overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  // Stage E registers
  logic                    r_e_valid;
  fu_op_t                  r_e_op;
  logic [GPR_SIZE-1:0]     r_e_a;
  logic [GPR_SIZE-1:0]     r_e_b;
  logic [ROB_IDX_SIZE-1:0] r_e_tag;
  logic [3:0]              r_e_nzcv;
  logic                    r_e_set;
  logic [3:0]              r_e_cond;

  // FIFO storage and control
  logic [GPR_SIZE-1:0]     r_mem_value [FIFO_DEPTH];
  logic [ROB_IDX_SIZE-1:0] r_mem_tag   [FIFO_DEPTH];
  logic                    r_mem_set   [FIFO_DEPTH];
  logic [3:0]              r_mem_nzcv  [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;

  // Registered head outputs
  logic                    r_ready;
  logic                    r_done;
  logic [GPR_SIZE-1:0]     r_out_value;
  logic [ROB_IDX_SIZE-1:0] r_out_tag;
  logic                    r_out_set;
  logic [3:0]              r_out_nzcv;
  logic                    r_overflow;

  logic [GPR_SIZE:0]       w_add;
  logic [GPR_SIZE:0]       w_sub;
  logic [GPR_SIZE-1:0]     w_res;
  logic [3:0]              w_flags;
  logic                    w_set;
  logic                    w_c;
  logic                    w_v;
  logic                    w_arith;
  logic                    w_logic;

  logic [OCC_W-1:0]        w_occ;
  logic [OCC_W-1:0]        w_occ_nxt;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_accept;
  logic                    w_drop;
  logic                    w_e_valid_nxt;
  logic [CNT_W-1:0]        w_count_nxt;
  logic [PTR_W-1:0]        w_rd_nxt;
  logic                    w_head_is_push;

  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
    logic base;
    case (cond[3:1])
      3'd0:    base = f[2];
      3'd1:    base = f[1];
      3'd2:    base = f[3];
      3'd3:    base = f[0];
      3'd4:    base = f[1] & ~f[2];
      3'd5:    base = (f[3] == f[0]);
      3'd6:    base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    cond_holds = (cond == 4'b1111) ? 1'b1 : (base ^ cond[0]);
  endfunction

  assign w_add = {1'b0, r_e_a} + {1'b0, r_e_b};
  assign w_sub = {1'b0, r_e_a} + {1'b0, ~r_e_b} + (GPR_SIZE+1)'(1);

  // Execute: result and flags of the op held in stage E
  always_comb begin
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_arith = 1'b0;
    w_logic = 1'b0;
    case (r_e_op)
      FU_OP_PLUS: begin
        w_res   = w_add[GPR_SIZE-1:0];
        w_c     = w_add[GPR_SIZE];
        w_v     = (r_e_a[GPR_SIZE-1] == r_e_b[GPR_SIZE-1]) &
                  (w_add[GPR_SIZE-1] != r_e_a[GPR_SIZE-1]);
        w_arith = 1'b1;
      end
      FU_OP_MINUS: begin
        w_res   = w_sub[GPR_SIZE-1:0];
        w_c     = w_sub[GPR_SIZE];
        w_v     = (r_e_a[GPR_SIZE-1] != r_e_b[GPR_SIZE-1]) &
                  (w_sub[GPR_SIZE-1] != r_e_a[GPR_SIZE-1]);
        w_arith = 1'b1;
      end
      FU_OP_AND: begin
        w_res   = r_e_a & r_e_b;
        w_logic = 1'b1;
      end
      FU_OP_ORR: begin
        w_res   = r_e_a | r_e_b;
        w_logic = 1'b1;
      end
      FU_OP_EOR: begin
        w_res   = r_e_a ^ r_e_b;
        w_logic = 1'b1;
      end
      FU_OP_LSL:    w_res = r_e_a << r_e_b[5:0];
      FU_OP_LSR:    w_res = r_e_a >> r_e_b[5:0];
      FU_OP_PASS_A: w_res = r_e_a;
      FU_OP_CSEL:   w_res = cond_holds(r_e_cond, r_e_nzcv) ? r_e_a : r_e_b;
      default:      w_res = '0;
    endcase
    w_set   = (w_arith | w_logic) & r_e_set;
    w_flags = w_set ? {w_res[GPR_SIZE-1], (w_res == '0), w_c, w_v} : r_e_nzcv;
  end

  // Occupancy counts stage E plus FIFO; a pop frees a slot on the same edge
  assign w_occ          = {1'b0, r_count} + OCC_W'(r_e_valid);
  assign w_full         = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop          = r_done & in_rob_accept & ~in_rob_is_mispred;
  assign w_push         = r_e_valid & (~w_full | w_pop) & ~in_rob_is_mispred;
  assign w_accept       = in_start & ~in_rob_is_mispred & (~r_e_valid | w_push) &
                          ((w_occ < OCC_W'(FIFO_DEPTH)) | w_pop);
  assign w_drop         = in_start & ~in_rob_is_mispred & ~w_accept;
  assign w_e_valid_nxt  = in_rob_is_mispred ? 1'b0 :
                          (w_accept | (r_e_valid & ~w_push));
  assign w_count_nxt    = in_rob_is_mispred ? '0 :
                          (r_count + CNT_W'(w_push) - CNT_W'(w_pop));
  assign w_occ_nxt      = {1'b0, w_count_nxt} + OCC_W'(w_e_valid_nxt);
  assign w_rd_nxt       = r_rd_ptr + PTR_W'(w_pop);
  assign w_head_is_push = w_push & (r_count == CNT_W'(w_pop));

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_e_valid <= 1'b0;
      r_e_op    <= FU_OP_PLUS;
      r_e_a     <= '0;
      r_e_b     <= '0;
      r_e_tag   <= '0;
      r_e_nzcv  <= '0;
      r_e_set   <= 1'b0;
      r_e_cond  <= '0;
    end else begin
      r_e_valid <= w_e_valid_nxt;
      if (w_accept) begin
        r_e_op   <= in_fu_op;
        r_e_a    <= in_val_a;
        r_e_b    <= in_val_b;
        r_e_tag  <= in_dst_rob_index;
        r_e_nzcv <= in_nzcv;
        r_e_set  <= in_set_nzcv;
        r_e_cond <= in_cond;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (w_push) begin
      r_mem_value[r_wr_ptr] <= w_res;
      r_mem_tag[r_wr_ptr]   <= r_e_tag;
      r_mem_set[r_wr_ptr]   <= w_set;
      r_mem_nzcv[r_wr_ptr]  <= w_flags;
    end
  end

  // Pointers, count, credit and sticky overflow
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_ready    <= (w_occ_nxt <= OCC_W'(FIFO_DEPTH - 2));
      r_overflow <= r_overflow | w_drop;
      if (in_rob_is_mispred) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
        r_rd_ptr <= w_rd_nxt;
      end
    end
  end

  // Head register: bypass the pushed entry when it becomes the new head
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_done      <= 1'b0;
      r_out_value <= '0;
      r_out_tag   <= '0;
      r_out_set   <= 1'b0;
      r_out_nzcv  <= '0;
    end else begin
      r_done <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        if (w_head_is_push) begin
          r_out_value <= w_res;
          r_out_tag   <= r_e_tag;
          r_out_set   <= w_set;
          r_out_nzcv  <= w_flags;
        end else begin
          r_out_value <= r_mem_value[w_rd_nxt];
          r_out_tag   <= r_mem_tag[w_rd_nxt];
          r_out_set   <= r_mem_set[w_rd_nxt];
          r_out_nzcv  <= r_mem_nzcv[w_rd_nxt];
        end
      end
    end
  end

  assign out_ready         = r_ready;
  assign out_done          = r_done;
  assign out_value         = r_out_value;
  assign out_dst_rob_index = r_out_tag;
  assign out_set_nzcv      = r_out_set;
  assign out_nzcv          = r_out_nzcv;
  assign out_overflow      = r_overflow;

endmodule

// File: tb/tb_alu_functional_unit.sv
// Bench for alu_functional_unit: directed scenarios plus random traffic
// against a queue-based behavioural model of issue, retirement and flags.
module tb_alu_functional_unit;
  import alu_functional_unit_pkg::*;

  localparam int unsigned GPR = 64;
  localparam int unsigned RIW = 4;
  localparam int unsigned DEPTH = 4;

  logic           in_clk = 1'b0;
  logic           in_rst;
  logic           in_start;
  fu_op_t         in_fu_op;
  logic [GPR-1:0] in_val_a;
  logic [GPR-1:0] in_val_b;
  logic [RIW-1:0] in_dst_rob_index;
  logic [3:0]     in_nzcv;
  logic           in_set_nzcv;
  logic [3:0]     in_cond;
  logic           in_rob_is_mispred;
  logic           in_rob_accept;
  logic           out_ready;
  logic           out_done;
  logic [GPR-1:0] out_value;
  logic [RIW-1:0] out_dst_rob_index;
  logic           out_set_nzcv;
  logic [3:0]     out_nzcv;
  logic           out_overflow;

  alu_functional_unit #(.GPR_SIZE(GPR), .ROB_IDX_SIZE(RIW), .FIFO_DEPTH(DEPTH)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_fu_op(in_fu_op),
    .in_val_a(in_val_a), .in_val_b(in_val_b), .in_dst_rob_index(in_dst_rob_index),
    .in_nzcv(in_nzcv), .in_set_nzcv(in_set_nzcv), .in_cond(in_cond),
    .in_rob_is_mispred(in_rob_is_mispred), .in_rob_accept(in_rob_accept),
    .out_ready(out_ready), .out_done(out_done), .out_value(out_value),
    .out_dst_rob_index(out_dst_rob_index), .out_set_nzcv(out_set_nzcv),
    .out_nzcv(out_nzcv), .out_overflow(out_overflow)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [63:0] value;
    logic [3:0]  tag;
    logic        set;
    logic [3:0]  nzcv;
    int          age;
  } exp_t;

  exp_t q[$];
  bit   ovf_exp;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] fl);
    bit n, z, c, v, base;
    n = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
    if (cond == 4'b1111) return 1'b1;
    case (int'(cond) / 2)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cond[0] ? !base : base;
  endfunction

  // Spec-level reference: signed overflow decided from operand/result signs
  task automatic ref_exec(input int op, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] fl, input logic sf, input logic [3:0] cond,
                          output logic [63:0] r, output logic [3:0] nz, output logic so);
    longint sa, sb, sr;
    bit c, v, arith, lg;
    logic [5:0] sh;
    c = 0; v = 0; arith = 0; lg = 0; r = 0;
    sa = a; sb = b; sh = b[5:0];
    case (op)
      0: begin r = a + b; sr = r; arith = 1; c = (r < a);
           v = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0); end
      1: begin r = a - b; sr = r; arith = 1; c = (a >= b);
           v = (sa >= 0 && sb < 0 && sr < 0) || (sa < 0 && sb >= 0 && sr >= 0); end
      2: begin r = a & b; lg = 1; end
      3: begin r = a | b; lg = 1; end
      4: begin r = a ^ b; lg = 1; end
      5: r = a << sh;
      6: r = a >> sh;
      7: r = a;
      8: r = cond_ok(cond, fl) ? a : b;
      default: r = 0;
    endcase
    so = (arith || lg) ? sf : 1'b0;
    nz = so ? {r[63], (r == 0), c, v} : fl;
  endtask

  task automatic check_outputs();
    bit d;
    d = (q.size() > 0) && (q[0].age >= 1);
    check("done", out_done, d);
    check("ready", out_ready, q.size() <= DEPTH - 2);
    check("overflow", out_overflow, ovf_exp);
    if (d) begin
      check("value", out_value, q[0].value);
      check("tag", out_dst_rob_index, q[0].tag);
      check("set_nzcv", out_set_nzcv, q[0].set);
      check("nzcv", out_nzcv, q[0].nzcv);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare
  task automatic step(input bit st, input int op, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] tag, input logic [3:0] fl, input bit sf,
                      input logic [3:0] cond, input bit mp, input bit acc);
    bit done_before, pop, took;
    exp_t e;
    in_start = st; in_fu_op = fu_op_t'(op[3:0]); in_val_a = a; in_val_b = b;
    in_dst_rob_index = tag; in_nzcv = fl; in_set_nzcv = sf; in_cond = cond;
    in_rob_is_mispred = mp; in_rob_accept = acc;
    done_before = (q.size() > 0) && (q[0].age >= 1);
    if (mp) begin
      q.delete();
    end else begin
      pop  = done_before && acc;
      took = st && ((q.size() < DEPTH) || pop);
      if (st && !took) ovf_exp = 1'b1;
      if (pop) q.delete(0);
      foreach (q[i]) q[i].age = q[i].age + 1;
      if (took) begin
        ref_exec(op, a, b, fl, sf, cond, e.value, e.nzcv, e.set);
        e.tag = tag;
        e.age = 0;
        q.push_back(e);
      end
    end
    @(posedge in_clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit acc);
    step(0, 0, 64'd0, 64'd0, 4'd0, 4'd0, 0, 4'd0, 0, acc);
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(0, 70));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic check_reset_values();
    check("rst_done", out_done, 0);
    check("rst_value", out_value, 0);
    check("rst_tag", out_dst_rob_index, 0);
    check("rst_set", out_set_nzcv, 0);
    check("rst_nzcv", out_nzcv, 0);
    check("rst_overflow", out_overflow, 0);
    check("rst_ready", out_ready, 1);
  endtask

  initial begin
    in_rst = 1'b1; in_start = 0; in_fu_op = FU_OP_PLUS; in_val_a = 0; in_val_b = 0;
    in_dst_rob_index = 0; in_nzcv = 0; in_set_nzcv = 0; in_cond = 0;
    in_rob_is_mispred = 0; in_rob_accept = 0;
    ovf_exp = 0;
    #3;
    check_reset_values();
    #4 in_rst = 1'b0;

    // PLUS overflow into the sign bit, two-edge latency
    step(1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd3, 4'd0, 1, 4'd0, 0, 0);
    check("plus_lat1_done", out_done, 0);
    idle(0);
    check("plus_done", out_done, 1);
    check("plus_value", out_value, 64'h8000_0000_0000_0000);
    check("plus_nzcv", out_nzcv, 4'b1001);
    check("plus_tag", out_dst_rob_index, 4'd3);
    idle(1);

    // MINUS equal operands, then CSEL on EQ
    step(1, 1, 64'd5, 64'd5, 4'd4, 4'd0, 1, 4'd0, 0, 1);
    step(1, 8, 64'd11, 64'd22, 4'd5, 4'b0100, 1, 4'b0000, 0, 1);
    check("minus_value", out_value, 64'd0);
    check("minus_nzcv", out_nzcv, 4'b0110);
    idle(1);
    check("csel_value", out_value, 64'd11);
    check("csel_set", out_set_nzcv, 0);
    idle(1);

    // Back-pressure: credit drops at occupancy 3, fifth start overflows
    for (int i = 0; i < 5; i++) begin
      step(1, 0, rnd_operand(), rnd_operand(), 4'(i + 1), 4'd0, 1, 4'd0, 0, 0);
      if (i == 2) check("bp_ready_low", out_ready, 0);
    end
    check("bp_overflow", out_overflow, 1);
    for (int i = 0; i < 6; i++) idle(1);

    // Eight back-to-back with continuous accept, pointers wrap
    for (int i = 0; i < 8; i++)
      step(1, $urandom_range(0, 8), rnd_operand(), rnd_operand(), 4'(i),
           4'($urandom), 1, 4'($urandom), 0, 1);
    idle(1);
    idle(1);
    check("b2b_empty", out_done, 0);

    // Mispredict with two queued results and a coincident start
    step(1, 2, rnd_operand(), rnd_operand(), 4'd9, 4'd0, 1, 4'd0, 0, 0);
    step(1, 3, rnd_operand(), rnd_operand(), 4'd10, 4'd0, 1, 4'd0, 0, 0);
    idle(0);
    step(1, 4, rnd_operand(), rnd_operand(), 4'd11, 4'd0, 1, 4'd0, 1, 1);
    check("mp_done", out_done, 0);
    check("mp_ready", out_ready, 1);
    for (int i = 0; i < 3; i++) idle(1);

    // Asynchronous reset between edges with a full FIFO
    for (int i = 0; i < 4; i++)
      step(1, 7, rnd_operand(), 64'd0, 4'(i), 4'd0, 0, 4'd0, 0, 0);
    idle(0);
    check("full_done", out_done, 1);
    #2 in_rst = 1'b1;
    #1 check_reset_values();
    q.delete();
    ovf_exp = 0;
    #2 in_rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit acc_hi;
      acc_hi = (n % 1000) > 500;
      step($urandom_range(0, 99) < 65, $urandom_range(0, 15), rnd_operand(), rnd_operand(),
           4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
           $urandom_range(0, 99) < 3,
           acc_hi ? ($urandom_range(0, 99) < 95) : ($urandom_range(0, 99) < 50));
    end
    for (int i = 0; i < 8; i++) idle(1);
    check("final_empty", out_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
